scan_ctrl: RTL and testbench
============================

// Module: scan_ctrl
// PURPOSE
//  Sequencer for a CHAIN_LEN-stage scan path built from smux2 + flip-flop cells.
//  - Drives the shared Test select and the chain head SDI.
//  - Collects the chain tail SDO.
//  - Runs one scan operation per Start: shift a pattern in, optionally capture
//    one functional cycle, shift the response out.
//  - Sits between the test host/bench and the scan-inserted datapath.
// PARAMETERS
//  CHAIN_LEN  16  scan stages in the chain (>=2)
//  CNT_W      5   bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN
// PORTS
//  Clock      in   1          single clock; also clocks the chain flops
//  nReset     in   1          asynchronous, active-low reset
//  Start      in   1          request a scan op; sampled only in IDLE
//  Abort      in   1          synchronous abort; returns to IDLE
//  CaptureEn  in   1          1: insert capture cycle; 0: loopback (no capture)
//  Pattern    in   CHAIN_LEN  shift-in data; latched at the Start edge
//  SDO        in   1          chain tail (stage CHAIN_LEN-1)
//  Test       out  1          to every smux2 Test pin; 1 = shift, 0 = functional
//  SDI        out  1          to chain head (stage 0)
//  Busy       out  1          high in any non-IDLE state
//  Done       out  1          one-cycle pulse; Result valid
//  Result     out  CHAIN_LEN  shifted-out response; held until next accepted Start
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset (async) drives Test=0, SDI=0, Busy=0, Done=0, Result=0, state=IDLE, cnt=0.
//  - Chain convention: the chain shifts on every rising edge with Test=1.
//    Stage 0 is fed by SDI; SDO = stage CHAIN_LEN-1.
//  - IDLE:
//    - Start=1 (and Abort=0) latches Pattern into the shift-out register.
//    - Sets Test<=1, SDI<=Pattern[CHAIN_LEN-1], cnt<=0; goes to SHIFT_IN.
//  - SHIFT_IN: CHAIN_LEN cycles, Test=1.
//    - Each edge: cnt++, SDI<=next bit, MSB first, ending with Pattern[0].
//    - After the last shift, Pattern[i] sits in stage i.
//    - At cnt==CHAIN_LEN-1:
//      - CaptureEn=1: Test<=0, go CAPTURE.
//      - CaptureEn=0: Test stays 1, go SHIFT_OUT.
//      - cnt<=0 in both cases.
//  - CAPTURE: exactly 1 cycle, Test=0; chain loads D.
//    - On exit: Test<=1, SDI<=0, go SHIFT_OUT.
//  - SHIFT_OUT: CHAIN_LEN cycles, Test=1, SDI=0.
//    - Each edge: Result<={Result[CHAIN_LEN-2:0],SDO}, sampling the pre-edge SDO.
//    - The first bit sampled (old stage CHAIN_LEN-1) ends in Result[CHAIN_LEN-1].
//    - At cnt==CHAIN_LEN-1: Test<=0, go DONE.
//  - DONE: Done=1, Busy=1 for one cycle, then IDLE.
//  - CaptureEn is sampled at the last SHIFT_IN cycle only.
//  - Latency, Start edge to Done high: 2*CHAIN_LEN+2 cycles (capture) or
//    2*CHAIN_LEN+1 cycles (loopback).
//  - Test-high time:
//    - Loopback: one contiguous 2*CHAIN_LEN-cycle window.
//    - Capture: two CHAIN_LEN-cycle windows separated by exactly one low cycle.
//  - Start while Busy: ignored. Pattern changes after the Start edge: no effect.
//  - Abort=1 in any non-IDLE state:
//    - Next edge: IDLE, Test=0, SDI=0, cnt=0, no Done.
//    - Result keeps its value, i.e. partial shifts are visible.
//    - Abort has priority over Start.
//  - nReset low mid-operation: outputs clear immediately (async).
//    - Test=0 returns the datapath to functional mode at once.
//  - Counter compare is against CHAIN_LEN-1; cnt never wraps past CHAIN_LEN-1.
// STRUCTURE
//  - scan_pkg: typedef enum logic [2:0] scan_state_t {IDLE, SHIFT_IN, CAPTURE,
//    SHIFT_OUT, DONE}.
//  - Sub-module scan_shreg #(W): parallel-load/serial shift register, MSB out,
//    LSB in. Instantiated twice: pattern shifter and result collector.
//  - FSM and counter live in scan_ctrl.
// TESTING (bench: 16 smux2+DFF stages, CHAIN_LEN=16)
//  1. Reset: nReset=0 during activity -> Test=0, SDI=0, Busy=0, Done=0, Result=16'h0000.
//  2. Loopback: CaptureEn=0, Pattern=16'hA5C3, Start
//     -> Test high 32 contiguous cycles, Done at cycle 33, Result=16'hA5C3.
//  3. Capture: chain D tied to 16'h1234, Pattern=16'hFFFF, CaptureEn=1
//     -> one Test-low cycle after 16 shifts, Done at cycle 34, Result=16'h1234;
//     chain holds 16'hFFFF after SHIFT_IN.
//  4. Start pulsed at cycle 10 of an op and Pattern changed
//     -> no restart, Result unaffected, single Done.
//  5. Abort at SHIFT_IN cycle 5 -> Test=0 and Busy=0 next cycle, no Done,
//     Result unchanged; the next Start runs a full op correctly.
//  6. nReset low mid SHIFT_OUT -> Test/Busy drop before the next edge;
//     after release, a fresh op returns the correct Result.

Source files
------------

// File: rtl/scan_pkg.sv
// scan_pkg: state encoding shared by the scan sequencer and its sub-blocks
package scan_pkg;
    typedef enum logic [2:0] {
        IDLE,
        SHIFT_IN,
        CAPTURE,
        SHIFT_OUT,
        DONE
    } scan_state_t;
endpackage

// File: rtl/scan_shreg.sv
// scan_shreg: parallel-load / serial shift register, MSB out, LSB in
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset, clears q_o
//   clr_i   in   synchronous clear (highest priority after reset)
//   load_i  in   parallel load of d_i
//   shift_i in   shift left by one, sin_i enters at bit 0
//   d_i     in   W-bit parallel data
//   sin_i   in   serial input
//   q_o     out  W-bit register contents; q_o[W-1] is the serial output
module scan_shreg #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] d_i,
    input  logic         sin_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] q_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) q_q <= '0;
        else if (clr_i) q_q <= '0;
        else if (load_i) q_q <= d_i;
        else if (shift_i) q_q <= {q_q[W-2:0], sin_i};
    end
    assign q_o = q_q;
endmodule

// File: rtl/scan_ctrl.sv
// scan_ctrl: sequencer for a CHAIN_LEN-stage smux2+DFF scan chain
//   Clock     in   single clock, also clocks the chain flops
//   nReset    in   asynchronous active-low reset
//   Start     in   request one scan op, sampled only in IDLE
//   Abort     in   synchronous abort back to IDLE, beats Start
//   CaptureEn in   1: one capture cycle between shifts, 0: loopback
//   Pattern   in   shift-in data, latched at the Start edge
//   SDO       in   chain tail (stage CHAIN_LEN-1)
//   Test      out  shared smux2 select, 1 = shift, 0 = functional
//   SDI       out  chain head (stage 0)
//   Busy      out  high in any non-IDLE state
//   Done      out  one-cycle pulse, Result valid
//   Result    out  shifted-out response, held until the next op overwrites it
module scan_ctrl
    import scan_pkg::*;
#(
    parameter int CHAIN_LEN = 16,
    parameter int CNT_W     = 5
) (
    input  logic                 Clock,
    input  logic                 nReset,
    input  logic                 Start,
    input  logic                 Abort,
    input  logic                 CaptureEn,
    input  logic [CHAIN_LEN-1:0] Pattern,
    input  logic                 SDO,
    output logic                 Test,
    output logic                 SDI,
    output logic                 Busy,
    output logic                 Done,
    output logic [CHAIN_LEN-1:0] Result
);
    scan_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic test_q, test_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic last;
    logic pat_load, pat_shift, pat_clr, res_shift;
    logic [CHAIN_LEN-1:0] pat_q;
    logic unused_pat;

    assign last = cnt_q == CNT_W'(CHAIN_LEN - 1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pat_load  = 1'b0;
        pat_shift = 1'b0;
        pat_clr   = 1'b0;
        res_shift = 1'b0;
        if (Abort && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
            pat_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start && !Abort) begin
                        state_d  = SHIFT_IN;
                        cnt_d    = '0;
                        pat_load = 1'b1;
                    end
                end
                SHIFT_IN: begin
                    // the final shift empties the pattern register, so SDI
                    // reads 0 for the rest of the op with no extra logic
                    pat_shift = 1'b1;
                    cnt_d     = last ? '0 : cnt_q + CNT_W'(1);
                    state_d   = last ? (CaptureEn ? CAPTURE : SHIFT_OUT) : SHIFT_IN;
                end
                CAPTURE: state_d = SHIFT_OUT;
                SHIFT_OUT: begin
                    res_shift = 1'b1;
                    cnt_d     = last ? '0 : cnt_q + CNT_W'(1);
                    state_d   = last ? DONE : SHIFT_OUT;
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        test_d = state_d == SHIFT_IN || state_d == SHIFT_OUT;
        busy_d = state_d != IDLE;
        done_d = state_d == DONE;
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            test_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            test_q  <= test_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // pattern shifter: its MSB is the registered SDI
    scan_shreg #(.W(CHAIN_LEN)) u_pat (
        .clk_i  (Clock),
        .rst_ni (nReset),
        .clr_i  (pat_clr),
        .load_i (pat_load),
        .shift_i(pat_shift),
        .d_i    (Pattern),
        .sin_i  (1'b0),
        .q_o    (pat_q)
    );

    // result collector: first bit sampled ends up in the MSB
    scan_shreg #(.W(CHAIN_LEN)) u_res (
        .clk_i  (Clock),
        .rst_ni (nReset),
        .clr_i  (1'b0),
        .load_i (1'b0),
        .shift_i(res_shift),
        .d_i    ('0),
        .sin_i  (SDO),
        .q_o    (Result)
    );

    // only the MSB leaves the pattern shifter
    assign unused_pat = ^pat_q[CHAIN_LEN-2:0];

    assign Test = test_q;
    assign SDI  = pat_q[CHAIN_LEN-1];
    assign Busy = busy_q;
    assign Done = done_q;
endmodule

// File: tb/tb_scan_ctrl.sv
// tb_scan_ctrl: directed bench for scan_ctrl driving a 16-stage smux2+DFF chain
module tb_scan_ctrl;
    localparam int N = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic cap = 1'b0;
    logic [N-1:0] pattern = '0;
    logic [N-1:0] chain = '0;
    logic [N-1:0] chain_d = '0;
    logic sdo, test, sdi, busy, done;
    logic [N-1:0] result;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] prev;
    int checks = 0;
    int passed = 0;
    int dones;

    always #5 clk = ~clk;

    // scan chain: smux2 selects SDI/previous stage when Test=1, functional D otherwise
    always @(posedge clk) chain <= test ? {chain[N-2:0], sdi} : chain_d;
    assign sdo = chain[N-1];

    scan_ctrl #(.CHAIN_LEN(N), .CNT_W(5)) dut (
        .Clock    (clk),
        .nReset   (rst_n),
        .Start    (start),
        .Abort    (abort),
        .CaptureEn(cap),
        .Pattern  (pattern),
        .SDO      (sdo),
        .Test     (test),
        .SDI      (sdi),
        .Busy     (busy),
        .Done     (done),
        .Result   (result)
    );

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // drive Start for one edge; returns at the negedge of cycle 1
    task automatic start_op(input logic [N-1:0] pat, input logic c);
        @(negedge clk);
        pattern = pat;
        cap = c;
        start = 1'b1;
        exp_q.push_back(c ? chain_d : pat);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp_cyc, input int exp_lows,
                             input int poke_cyc, input int chain_cyc, input logic [N-1:0] chain_exp);
        int highs = 0;
        int lows = 0;
        bit seen = 1'b0;
        logic [N-1:0] exp;
        for (int k = 1; k <= 60 && !seen; k++) begin
            if (k == chain_cyc) check({tag, "_chain"}, chain, chain_exp);
            if (done) begin
                seen = 1'b1;
                exp = exp_q.size() != 0 ? exp_q.pop_front() : 'x;
                check({tag, "_done_cycle"}, N'(k), N'(exp_cyc));
                check({tag, "_result"}, result, exp);
                check({tag, "_test_high"}, N'(highs), N'(32));
                check({tag, "_test_low"}, N'(lows), N'(exp_lows));
                @(negedge clk);
                check({tag, "_after_done"}, {14'b0, done, busy}, '0);
            end else begin
                if (test) highs++;
                else lows++;
                start = k == poke_cyc;
                if (k == poke_cyc) pattern = ~pattern;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) check({tag, "_done_timeout"}, '0, 16'd1);
    endtask

    initial begin
        // 1: reset held while inputs are active
        start = 1'b1;
        pattern = 16'hFFFF;
        cap = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_ctl", {12'b0, test, sdi, busy, done}, '0);
        check("reset_result", result, '0);
        rst_n = 1'b1;
        start = 1'b0;

        // 2: loopback
        start_op(16'hA5C3, 1'b0);
        wait_done("loopback", 33, 0, 0, 0, '0);

        // 3: capture with functional D tied to 16'h1234
        chain_d = 16'h1234;
        start_op(16'hFFFF, 1'b1);
        wait_done("capture", 34, 1, 0, 17, 16'hFFFF);

        // 4: Start and Pattern change mid-op are ignored
        start_op(16'h3C5A, 1'b0);
        wait_done("restart", 33, 0, 10, 0, '0);
        dones = 0;
        repeat (40) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("restart_extra_done", N'(dones), '0);

        // 5: abort during SHIFT_IN
        prev = result;
        start_op(16'h0F0F, 1'b0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ctl", {13'b0, test, busy, sdi}, '0);
        void'(exp_q.pop_front());
        dones = 0;
        repeat (40) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("abort_no_done", N'(dones), '0);
        check("abort_result", result, prev);
        chain_d = 16'hBEEF;
        start_op(16'h8001, 1'b1);
        wait_done("after_abort", 34, 1, 0, 17, 16'h8001);

        // 6: async reset during SHIFT_OUT
        start_op(16'h5555, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_ctl", {12'b0, test, busy, done, sdi}, '0);
        check("async_rst_result", result, '0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        start_op(16'hC0DE, 1'b0);
        wait_done("after_reset", 33, 0, 0, 0, '0);
        check("queue_empty", N'(exp_q.size()), '0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
